// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan controller and its settle counter.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/dwell_cnt.sv
// Settle counter: cleared on SETTLE entry, counts SETTLE cycles, flags the last one.
module dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the DWELL-th settle cycle, so the next state is SAMPLE.
  assign tc_c = en_i && (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through all channels, settles, samples y and publishes data.
// Define MUX_SCAN_CONT_EN to let start in DONE launch the next scan directly.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              y,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] data
);

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic                busy_q;
  logic                done_q;
  logic [NUM_CH-1:0]   data_q;
  logic [NUM_CH-2:0]   shadow_q;

  logic                cont_start_c;
  logic                clr_c;
  logic                en_c;
  logic                tc_c;

`ifdef MUX_SCAN_CONT_EN
  assign cont_start_c = start;
`else
  assign cont_start_c = 1'b0;
`endif

  // Counter restarts on every SETTLE entry and only runs while settling.
  assign clr_c = ((state_q == IDLE)   && start) ||
                 ((state_q == SAMPLE) && (sel_q != LAST_CH)) ||
                 ((state_q == DONE)   && cont_start_c);
  assign en_c  = (state_q == SETTLE);

  dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_c),
    .en_i  (en_c),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETTLE;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (tc_c) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
            if (sel_q == SEL_W'(k)) begin
              shadow_q[k] <= y;
            end
          end
          if (sel_q != LAST_CH) begin
            sel_q   <= sel_q + SEL_W'(1);
            state_q <= SETTLE;
          end else begin
            // Last channel goes straight into data so partial scans never leak out.
            data_q  <= {y, shadow_q};
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          sel_q <= '0;
          if (cont_start_c) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance at DWELL=2, one at DWELL=1.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] mux_a, mux_b;
  logic       y_a, y_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [3:0] data_a, data_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Model of the downstream 4:1 muxes.
  assign y_a = mux_a[sel_a];
  assign y_b = mux_b[sel_b];

  mux_scan_ctrl #(.DWELL(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y(y_a),
    .sel(sel_a), .busy(busy_a), .done(done_a), .data(data_a)
  );

  mux_scan_ctrl #(.DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b),
    .sel(sel_b), .busy(busy_b), .done(done_b), .data(data_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; mux_a = 4'h0; mux_b = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (sel_a  !== 2'd0) begin bad++; $display("FAIL reset_sel_a got=%0h exp=0", sel_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%0b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%0b exp=0", done_a); end
    total++; if (data_a !== 4'h0) begin bad++; $display("FAIL reset_data_a got=%0h exp=0", data_a); end
    total++; if (sel_b  !== 2'd0) begin bad++; $display("FAIL reset_sel_b got=%0h exp=0", sel_b); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%0b exp=0", busy_b); end
    total++; if (done_b !== 1'b0) begin bad++; $display("FAIL reset_done_b got=%0b exp=0", done_b); end
    total++; if (data_b !== 4'h0) begin bad++; $display("FAIL reset_data_b got=%0h exp=0", data_b); end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  // DWELL=2: sel 0,1,2,3 for three cycles each, busy cycles 1..12, done in cycle 13.
  task automatic test_scan_d2;
    logic [1:0] exp_sel;
    mux_a = 4'b1010; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      exp_sel = (n <= 12) ? 2'((n - 1) / 3) : ((n == 13) ? 2'd3 : 2'd0);
      total++; if (sel_a !== exp_sel) begin bad++; $display("FAIL scan_d2_sel cyc=%0d got=%0h exp=%0h", n, sel_a, exp_sel); end
      total++; if (busy_a !== (n <= 12)) begin bad++; $display("FAIL scan_d2_busy cyc=%0d got=%0b exp=%0b", n, busy_a, (n <= 12)); end
      total++; if (done_a !== (n == 13)) begin bad++; $display("FAIL scan_d2_done cyc=%0d got=%0b exp=%0b", n, done_a, (n == 13)); end
      if (n == 13) begin
        total++; if (data_a !== 4'b1010) begin bad++; $display("FAIL scan_d2_data got=%0b exp=1010", data_a); end
      end
      tick;
    end
  endtask

  // DWELL=1: done in cycle 9; data holds the first result until the second done.
  task automatic test_scan_d1;
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
    mux_b = 4'b0110; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      exp_sel = (n <= 8) ? 2'((n - 1) / 2) : 2'd3;
      total++; if (sel_b !== exp_sel) begin bad++; $display("FAIL scan_d1_sel cyc=%0d got=%0h exp=%0h", n, sel_b, exp_sel); end
      total++; if (done_b !== (n == 9)) begin bad++; $display("FAIL scan_d1_done cyc=%0d got=%0b exp=%0b", n, done_b, (n == 9)); end
      if (n == 9) begin
        total++; if (data_b !== 4'b0110) begin bad++; $display("FAIL scan_d1_data1 got=%0b exp=0110", data_b); end
      end
      tick;
    end
    mux_b = 4'b1001; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      exp_data = (n == 9) ? 4'b1001 : 4'b0110;
      total++; if (done_b !== (n == 9)) begin bad++; $display("FAIL scan_d1_done2 cyc=%0d got=%0b exp=%0b", n, done_b, (n == 9)); end
      total++; if (data_b !== exp_data) begin bad++; $display("FAIL scan_d1_data2 cyc=%0d got=%0b exp=%0b", n, data_b, exp_data); end
      tick;
    end
  endtask

  // start re-pulsed while channel 2 settles must not restart or queue a scan.
  task automatic test_restart;
    int ndone = 0;
    mux_a = 4'b0101; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      total++; if (busy_a !== (n <= 12)) begin bad++; $display("FAIL restart_busy cyc=%0d got=%0b exp=%0b", n, busy_a, (n <= 12)); end
      if (done_a === 1'b1) ndone++;
      if (n == 13) begin
        total++; if (data_a !== 4'b0101) begin bad++; $display("FAIL restart_data got=%0b exp=0101", data_a); end
      end
      if (n == 7) start_a = 1'b1;
      if (n == 8) start_a = 1'b0;
      tick;
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL restart_done_count got=%0d exp=1", ndone); end
  endtask

  // Bits glitch during SETTLE; only the SAMPLE-cycle value is captured.
  task automatic test_toggle;
    mux_a = 4'b0000; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 13) begin
        total++; if (data_a !== 4'b0100) begin bad++; $display("FAIL toggle_data got=%0b exp=0100", data_a); end
      end
      if (n == 4)  mux_a[1] = 1'b1;
      if (n == 5)  mux_a[1] = 1'b0;
      if (n == 7)  mux_a[2] = 1'b1;
      if (n == 10) mux_a[3] = 1'b1;
      if (n == 11) mux_a[3] = 1'b0;
      tick;
    end
  endtask

  // Reset during the channel-1 SAMPLE cycle clears everything without a clock edge.
  task automatic test_reset_mid;
    bit seen = 1'b0;
    mux_a = 4'b1111; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int n = 1; n <= 5; n++) tick;
    total++; if (sel_a !== 2'd1) begin bad++; $display("FAIL rmid_pre_sel got=%0h exp=1", sel_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sel_a  !== 2'd0) begin bad++; $display("FAIL rmid_sel got=%0h exp=0", sel_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rmid_done got=%0b exp=0", done_a); end
    total++; if (data_a !== 4'h0) begin bad++; $display("FAIL rmid_data_a got=%0h exp=0", data_a); end
    total++; if (data_b !== 4'h0) begin bad++; $display("FAIL rmid_data_b got=%0h exp=0", data_b); end
    tick; tick;
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick;
      if (busy_a !== 1'b0 || done_a !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_activity_after_release got=%0b exp=0", seen); end
  endtask

  // start held high: continuous build repeats every 13 cycles, default build stops after one.
  task automatic test_cont;
    int last;
    bit exp_done, exp_busy;
    last = CONT ? 40 : 14;
    start_a = 1'b1;
    tick;
    for (int n = 1; n <= last; n++) begin
      exp_done = ((n % 13) == 0);
      exp_busy = CONT ? !exp_done : (n < 13);
      total++; if (done_a !== exp_done) begin bad++; $display("FAIL cont_done cyc=%0d got=%0b exp=%0b", n, done_a, exp_done); end
      total++; if (busy_a !== exp_busy) begin bad++; $display("FAIL cont_busy cyc=%0d got=%0b exp=%0b", n, busy_a, exp_busy); end
      if (n == 13) begin
        total++; if (data_a !== 4'b1111) begin bad++; $display("FAIL cont_data got=%0b exp=1111", data_a); end
      end
      if (n == last) start_a = 1'b0;
      tick;
    end
    total++; if (busy_a !== CONT) begin bad++; $display("FAIL cont_tail_busy got=%0b exp=%0b", busy_a, CONT); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL cont_tail_done got=%0b exp=0", done_a); end
  endtask

  initial begin
    test_reset;
    test_scan_d2;
    test_scan_d1;
    test_restart;
    test_toggle;
    test_reset_mid;
    test_cont;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, 2, settle cycles per channel before sampling; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  scan request, sampled on rising edge.
REQ-005 Port: y  input  1  selected bit returned from the downstream 4:1 mux.
REQ-006 Port: sel  output  2  channel select driven to the 4:1 mux.
REQ-007 Port: busy  output  1  high while a scan is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking a completed scan.
REQ-009 Port: data  output  4  captured channels; bit k = y sampled while sel==k.

Function
REQ-010 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-011 IDLE: start=1 -> sel<=0, dwell counter<=0, go SETTLE; start=0 -> stay.
REQ-012 SETTLE: counter increments each cycle; after DWELL cycles in SETTLE -> SAMPLE.
REQ-013 SAMPLE (one cycle): shadow[sel]<=y; sel<3 -> sel<=sel+1, counter<=0, go SETTLE; sel==3 -> data<={y,shadow[2:0]}, go DONE.
REQ-014 DONE (one cycle): done=1, busy=0, sel<=0, go IDLE (see REQ-023 for the compiled-in variant).
REQ-015 busy SHALL equal 1 exactly in SETTLE and SAMPLE.
REQ-016 Latency: with start sampled at edge 0, done SHALL be high in cycle 4*(DWELL+1)+1 and data SHALL be valid in that same cycle.
REQ-017 data SHALL hold its value from one DONE until the next DONE; partial scans never change data.
REQ-018 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-019 sel SHALL change only on SETTLE entry, so y is stable for at least DWELL cycles before it is sampled.
REQ-020 The dwell counter SHALL be 8 bits wide and SHALL never wrap within a channel.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, sel=0, busy=0, done=0, data=0, shadow=0, counter=0, independent of clk.
REQ-022 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first scan after release needs a fresh start.

Configuration
REQ-023 Macro MUX_SCAN_CONT_EN defined: in DONE, start=1 -> sel<=0, counter<=0, go SETTLE directly, so back-to-back scans repeat every 4*(DWELL+1)+1 cycles; start=0 -> IDLE.
REQ-024 Macro MUX_SCAN_CONT_EN undefined: DONE always goes to IDLE, and start is ignored in DONE.

Structure
REQ-025 Package mux_scan_pkg SHALL hold the state enum, NUM_CH=4, SEL_W=2 and CNT_W=8.
REQ-026 Sub-module dwell_cnt (clear, enable, terminal-count output at DWELL) SHALL implement the settle counter; the FSM, shadow and data registers stay at top level.

Verification
REQ-027 DWELL=2, mux inputs held at 4'b1010, start pulse -> sel steps 0,1,2,3, busy high for 12 cycles, done high in cycle 13, data=4'b1010.
REQ-028 DWELL=1, inputs 4'b0110, then 4'b1001 applied after done -> second scan gives data=4'b1001, and data holds 4'b0110 until the second done.
REQ-029 start re-pulsed during SETTLE of channel 2 -> no restart, exactly one done, data correct.
REQ-030 rst_n pulled low during SAMPLE of channel 1 -> all outputs 0 asynchronously; no done after release until a new start.
REQ-031 With MUX_SCAN_CONT_EN defined, DWELL=2 and start held high -> done pulses every 13 cycles, busy low only in DONE cycles; without the macro -> one done, then IDLE.
REQ-032 An input bit toggled during SETTLE but stable at SAMPLE -> the captured bit equals the SAMPLE-cycle value.
